// File: rtl/irom_port_arbiter_if.sv
// Bus bundle between the instruction ROM arbiter, its two requesters
// (fetch port F, data/debug port D) and the single-port ROM.
//   slave  : arbiter view (takes requests and ROM data, drives grants,
//            responses and the ROM word address)
//   master : requester/ROM view (the opposite directions)
interface irom_port_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int IROM_AW = 10,
  parameter int DATA_W  = 32
);
  logic               f_req;
  logic [ADDR_W-1:0]  f_addr;
  logic               f_gnt;
  logic               f_rvalid;
  logic [DATA_W-1:0]  f_rdata;

  logic               d_req;
  logic [ADDR_W-1:0]  d_addr;
  logic               d_gnt;
  logic               d_rvalid;
  logic [DATA_W-1:0]  d_rdata;
  logic               d_err;

  logic [IROM_AW-1:0] irom_addr;
  logic [DATA_W-1:0]  irom_dout;

  modport slave (
    input  f_req, f_addr, d_req, d_addr, irom_dout,
    output f_gnt, f_rvalid, f_rdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output irom_addr
  );

  modport master (
    output f_req, f_addr, d_req, d_addr, irom_dout,
    input  f_gnt, f_rvalid, f_rdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  irom_addr
  );
endinterface

// File: rtl/irom_port_arbiter.sv
// Arbiter/sequencer for the single-port synchronous instruction ROM.
// Fetch (F) normally wins; data/debug (D) wins when F is idle or after it
// has been denied MAX_WAIT consecutive cycles. One access per cycle, read
// data returned exactly one cycle after the grant.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : irom_port_arbiter_if.slave (requests, grants, responses,
//           ROM word address and ROM read data)
module irom_port_arbiter #(
  parameter int          ADDR_W    = 32,
  parameter int          IROM_AW   = 10,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WAIT  = 4
) (
  input logic                clk,
  input logic                rst_n,
  irom_port_arbiter_if.slave bus
);

  logic [ADDR_W-1:0]  f_off;
  logic [ADDR_W-1:0]  d_off;
  logic [IROM_AW-1:0] f_idx;
  logic [IROM_AW-1:0] d_idx;
  logic               d_error;
  logic               starve;
  logic               f_gnt_c;
  logic               d_gnt_c;
  logic [IROM_AW-1:0] addr_c;
  logic [IROM_AW-1:0] addr_q;
  logic [3:0]         wait_cnt;
  logic               f_rvalid_q;
  logic               d_rvalid_q;
  logic               d_err_q;
  logic               unused_bits;

  // Offsets wrap modulo 2^ADDR_W, so addresses below BASE_ADDR land far out
  // of range for D and alias into the ROM for F.
  assign f_off   = bus.f_addr - BASE_ADDR[ADDR_W-1:0];
  assign d_off   = bus.d_addr - BASE_ADDR[ADDR_W-1:0];
  assign f_idx   = f_off[IROM_AW+1:2];
  assign d_idx   = d_off[IROM_AW+1:2];
  assign d_error = (bus.d_addr[1:0] != 2'b00) ||
                   (d_off[ADDR_W-1:IROM_AW+2] != '0);

  // Fetch has no range check, so its upper offset bits are dropped.
  assign unused_bits = &{1'b0, f_off[ADDR_W-1:IROM_AW+2], f_off[1:0], d_off[1:0]};

  assign starve  = (wait_cnt == 4'(MAX_WAIT));
  assign d_gnt_c = rst_n && bus.d_req && (starve || !bus.f_req);
  assign f_gnt_c = rst_n && bus.f_req && !d_gnt_c;

  // The address follows a grant in the same cycle; otherwise (idle or an
  // erroring D access) it holds so the ROM output stays stable.
  always_comb begin
    addr_c = addr_q;
    if (f_gnt_c)
      addr_c = f_idx;
    else if (d_gnt_c && !d_error)
      addr_c = d_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wait_cnt   <= '0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      addr_q     <= addr_c;
      f_rvalid_q <= f_gnt_c;
      d_rvalid_q <= d_gnt_c;
      d_err_q    <= d_gnt_c && d_error;
      if (bus.d_req && !d_gnt_c) begin
        if (!starve)
          wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign bus.f_gnt     = f_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.irom_addr = addr_c;
  assign bus.f_rvalid  = f_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_err     = d_err_q;
  assign bus.f_rdata   = f_rvalid_q ? bus.irom_dout : '0;
  assign bus.d_rdata   = (d_rvalid_q && !d_err_q) ? bus.irom_dout : '0;

endmodule

// File: tb/tb_irom_port_arbiter.sv
module tb_irom_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  irom_port_arbiter_if bus ();

  irom_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [9:0] i);
    return {16'hC0DE, 6'd0, i} ^ {i, 22'd0};
  endfunction

  // Behavioural synchronous ROM: output one cycle after the address.
  always @(posedge clk) bus.irom_dout <= rom_word(bus.irom_addr);

  typedef struct {
    logic        rst_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        f_gnt;
    logic        d_gnt;
    logic [9:0]  addr;
    logic        f_rv;
    logic        d_rv;
    logic        d_err;
    logic [31:0] f_data;
    logic [31:0] d_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic fr, input logic [31:0] fa,
                     input logic dr, input logic [31:0] da,
                     input logic fg, input logic dg, input logic [9:0] ad,
                     input logic frv, input logic drv, input logic derr,
                     input logic [31:0] fd, input logic [31:0] dd);
    vec_t v;
    v.rst_n = r;  v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_addr = da;
    v.f_gnt = fg; v.d_gnt = dg; v.addr = ad;
    v.f_rv = frv; v.d_rv = drv; v.d_err = derr; v.f_data = fd; v.d_data = dd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // rst f_req f_addr d_req d_addr | f_gnt d_gnt addr | f_rv d_rv err f_data d_data
    for (int i = 0; i < 3; i++)
      add(0, 1, 32'h10, 1, 32'h20, 0, 0, 10'd0, 0, 0, 0, 0, 0);
    // single fetch, then back-to-back, then idle hold
    add(1, 1, 32'h10,   0, 32'h0,  1, 0, 10'd4,  1, 0, 0, rom_word(4), 0);
    add(1, 1, 32'h0,    0, 32'h0,  1, 0, 10'd0,  1, 0, 0, rom_word(0), 0);
    add(1, 1, 32'h4,    0, 32'h0,  1, 0, 10'd1,  1, 0, 0, rom_word(1), 0);
    add(1, 1, 32'h8,    0, 32'h0,  1, 0, 10'd2,  1, 0, 0, rom_word(2), 0);
    add(1, 0, 32'h0,    0, 32'h0,  0, 0, 10'd2,  0, 0, 0, 0, 0);
    // starvation: F,F,F,F,D twice
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++)
        add(1, 1, 32'h40, 1, 32'h20, 1, 0, 10'd16, 1, 0, 0, rom_word(16), 0);
      add(1, 1, 32'h40, 1, 32'h20, 0, 1, 10'd8, 0, 1, 0, 0, rom_word(8));
    end
    // D errors hold the address at the last good access (8)
    add(1, 0, 32'h0,    1, 32'h2,    0, 1, 10'd8,  0, 1, 1, 0, 0);
    add(1, 0, 32'h0,    1, 32'h1000, 0, 1, 10'd8,  0, 1, 1, 0, 0);
    add(1, 0, 32'h0,    1, 32'h44,   0, 1, 10'd17, 0, 1, 0, 0, rom_word(17));
    // last in-range word for D, then F out-of-range aliasing
    add(1, 0, 32'h0,    1, 32'hFFC,  0, 1, 10'd1023, 0, 1, 0, 0, rom_word(1023));
    add(1, 1, 32'h1008, 0, 32'h0,    1, 0, 10'd2,  1, 0, 0, rom_word(2), 0);
    // D below BASE wraps out of range; simultaneous req with fresh counter: F wins
    add(1, 0, 32'h0,    1, 32'hFFFF_FFFC, 0, 1, 10'd2, 0, 1, 1, 0, 0);
    add(1, 1, 32'hC,    1, 32'h30,   1, 0, 10'd3,  1, 0, 0, rom_word(3), 0);

    bus.f_req = 0; bus.f_addr = 0; bus.d_req = 0; bus.d_addr = 0;
    rst_n = 0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      bus.f_req = vecs[i].f_req;  bus.f_addr = vecs[i].f_addr;
      bus.d_req = vecs[i].d_req;  bus.d_addr = vecs[i].d_addr;
      @(negedge clk);
      chk($sformatf("v%0d f_gnt", i), 32'(bus.f_gnt), 32'(vecs[i].f_gnt));
      chk($sformatf("v%0d d_gnt", i), 32'(bus.d_gnt), 32'(vecs[i].d_gnt));
      chk($sformatf("v%0d irom_addr", i), 32'(bus.irom_addr), 32'(vecs[i].addr));
      @(posedge clk); #1;
      chk($sformatf("v%0d f_rvalid", i), 32'(bus.f_rvalid), 32'(vecs[i].f_rv));
      chk($sformatf("v%0d d_rvalid", i), 32'(bus.d_rvalid), 32'(vecs[i].d_rv));
      chk($sformatf("v%0d d_err", i), 32'(bus.d_err), 32'(vecs[i].d_err));
      chk($sformatf("v%0d f_rdata", i), bus.f_rdata, vecs[i].f_data);
      chk($sformatf("v%0d d_rdata", i), bus.d_rdata, vecs[i].d_data);
    end

    // Reset mid-flight: fetch granted in cycle N, reset at the edge ending N.
    rst_n = 1; bus.d_req = 0; bus.f_req = 1; bus.f_addr = 32'h14;
    @(negedge clk);
    chk("mid f_gnt before reset", 32'(bus.f_gnt), 32'd1);
    chk("mid irom_addr before reset", 32'(bus.irom_addr), 32'd5);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid f_rvalid cleared", 32'(bus.f_rvalid), 32'd0);
    chk("mid f_rdata cleared", bus.f_rdata, 32'd0);
    chk("mid f_gnt in reset", 32'(bus.f_gnt), 32'd0);
    chk("mid irom_addr reset", 32'(bus.irom_addr), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("mid f_gnt resumed", 32'(bus.f_gnt), 32'd1);
    chk("mid irom_addr resumed", 32'(bus.irom_addr), 32'd5);
    @(posedge clk); #1;
    chk("mid f_rvalid resumed", 32'(bus.f_rvalid), 32'd1);
    chk("mid f_rdata resumed", bus.f_rdata, rom_word(5));

    // Counter cleared by reset: D must wait four full denials again.
    bus.d_req = 1; bus.d_addr = 32'h24;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("restart d_gnt c%0d", k), 32'(bus.d_gnt), (k == 4) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    chk("restart d_rdata", bus.d_rdata, rom_word(9));
    bus.f_req = 0; bus.d_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irom_port_arbiter.md
# irom_port_arbiter

Arbiter and sequencer for the single-port synchronous instruction ROM. Shares the ROM between the instruction-fetch requester (port F) and a data-side/debug read requester (port D). Grants at most one access per cycle and drives the ROM word address. Returns each read one cycle later with a per-port valid and an alignment/range error for port D.

## Interface
- ADDR_W, 32: byte-address width of both requesters (architecture width).
- IROM_AW, 10: ROM word-address width; ROM holds 2^IROM_AW 32-bit words.
- DATA_W, 32: ROM data width.
- BASE_ADDR, 32'h0000_0000: byte address mapped to ROM word 0.
- MAX_WAIT, 4: consecutive denied cycles after which port D wins arbitration (1..15).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- f_req  in  1  fetch request.
- f_addr  in  ADDR_W  fetch byte address.
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_rvalid  out  1  fetch read data valid (registered).
- f_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data/debug request.
- d_addr  in  ADDR_W  data byte address.
- d_gnt  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  data read data valid (registered).
- d_rdata  out  DATA_W  data read data.
- d_err  out  1  qualifies d_rvalid: access misaligned or outside ROM window.
- irom_addr  out  IROM_AW  word address to ROM (registered-hold, see below).
- irom_dout  in  DATA_W  ROM output, valid one cycle after address is sampled.

## Operation
- Offset = addr − BASE_ADDR (ADDR_W bits, wraps modulo 2^ADDR_W). In range iff offset[ADDR_W-1:IROM_AW+2] == 0. Word index = offset[IROM_AW+1:2].
- Arbitration per cycle, only when rst_n = 1:
  - starve = (wait_cnt == MAX_WAIT).
  - d_req && (starve || !f_req) → d_gnt = 1.
  - else f_req → f_gnt = 1.
  - Never both grants; no grant when neither requests.
- wait_cnt (4 bits): d_req && !d_gnt → increment, saturating at MAX_WAIT; otherwise → 0.
- irom_addr: the granted port's word index in the grant cycle; holds its previous value when there is no grant or when a port-D error access is granted. The ROM output therefore stays stable while idle.
- Port F performs no error check. An out-of-range fetch reads the aliased word (index bits only).
- Port D error = addr[1:0] != 0 or not in range. An erroring grant still consumes the slot but does not change irom_addr.
- Response registers, loaded every edge:
  - f_rvalid ← f_gnt.
  - d_rvalid ← d_gnt.
  - d_err ← d_gnt && error.
- Data outputs:
  - f_rdata = f_rvalid ? irom_dout : 0.
  - d_rdata = (d_rvalid && !d_err) ? irom_dout : 0.
- Reset (rst_n = 0 at an edge): f_rvalid, d_rvalid, d_err, wait_cnt, irom_addr ← 0. Grants are forced 0 while rst_n = 0, so f_rdata and d_rdata read 0.
- Reset mid-operation: a grant issued in the cycle before reset asserts has its rvalid cleared by reset. No response is delivered after reset for pre-reset requests.

## Timing
- Cycle N: req high and gnt high; irom_addr presents the index, sampled by the ROM at the end of N.
- Cycle N+1: the port's rvalid = 1 and rdata = ROM word. Latency is exactly 1 cycle.
- Throughput is one access per cycle, back-to-back, with ports in any order.
- A requester must hold req/addr until its gnt; the arbiter does not latch requests.
- Simultaneous req on both ports: F wins until D has been denied MAX_WAIT cycles. D then wins exactly once and wait_cnt clears.
- With MAX_WAIT = 4 and both requesting continuously, the grant pattern is F,F,F,F,D repeating.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with f_req = d_req = 1 → no gnt; rvalids, d_err and irom_addr are 0 after each edge.
- Single fetch: f_req = 1, f_addr = BASE_ADDR + 0x10 → f_gnt in the same cycle and irom_addr = 4. Next cycle f_rvalid = 1 and f_rdata = ROM[4]. d_rvalid stays 0.
- Back-to-back fetch: f_addr = 0x0, 0x4, 0x8 on consecutive cycles → f_rvalid high 3 cycles with ROM[0], ROM[1], ROM[2] in order.
- Starvation: both ports request continuously, MAX_WAIT = 4, d_addr = BASE_ADDR + 0x20 → d_gnt on the 5th cycle only. d_rvalid returns ROM[8] the next cycle; pattern repeats every 5 cycles.
- D error cases, each → d_rvalid = 1, d_err = 1, d_rdata = 0, irom_addr unchanged from the prior access:
  - d_addr = BASE_ADDR + 0x2 (misaligned).
  - d_addr = BASE_ADDR + 0x1000 (out of range, IROM_AW = 10).
- Reset mid-flight: grant F at cycle N, assert rst_n = 0 at the edge ending N → f_rvalid = 0 in N+1. Normal arbitration resumes the cycle after rst_n returns to 1.
